// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C master arbiter.
// Contents: the FSM state encoding, the command field widths, and a clog2
// helper that sizes the grant index and the internal counters.
package i2c_arb_pkg;

  localparam int ADDR_W  = 7;
  localparam int NBYTE_W = 5;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  // Returns the smallest r such that 2**r >= value. It returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value > (32'sd1 <<< i)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector.
// It searches i_req starting at index i_rr+1 and moves upward, wrapping
// around past the top index. It returns the first requesting index.
// Ports:
//   i_req   [NREQ]  request vector
//   i_rr    [IDX_W] index granted last time (lowest priority this round)
//   o_idx   [IDX_W] selected index (0 when nothing requests)
//   o_found         high when any request is present
module i2c_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_rr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk the candidates from farthest to nearest, so the nearest requester after rr wins
  always_comb begin
    o_idx   = {IDX_W{1'b0}};
    o_found = 1'b0;
    w_sum   = {SUM_W{1'b0}};
    w_cand  = {IDX_W{1'b0}};
    for (int k = NREQ; k >= 1; k--) begin
      w_sum   = {1'b0, i_rr} + SUM_W'(k);
      // The sum is below 2*NREQ, so one conditional subtract does the modulo
      w_cand  = (w_sum >= SUM_W'(NREQ)) ? IDX_W'(w_sum - SUM_W'(NREQ)) : w_sum[IDX_W-1:0];
      o_idx   = i_req[w_cand] ? w_cand : o_idx;
      o_found = o_found | i_req[w_cand];
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master core between NREQ clients.
// In IDLE it grants one client. It then latches that client's command,
// strobes the core enable and steers the write pops and read strobes.
// A transaction ends in one of two ways:
//   - a rising edge on the core's free level for the current direction, or
//   - the watchdog expiring.
// A fixed idle gap is enforced before the next grant.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req/req_rw/req_addr/req_nbyte   per-client request and command fields
//   req_wdata                       per-client show-ahead write byte
//   wdata_pop/rvalid/done/err       one-hot per-client pulses
//   rdata                           read byte broadcast to all clients
//   busy                            high from grant until back in IDLE
//   core_ena/core_rw/core_addr/core_nbyte/core_wdata   command to the core
//   core_req_w/core_valid/core_rdata/core_free_w/core_free_r  status from the core
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096,
  parameter int BUS_GAP = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_rw,
  input  logic [ADDR_W*NREQ-1:0]  req_addr,
  input  logic [NBYTE_W*NREQ-1:0] req_nbyte,
  input  logic [DATA_W*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]         wdata_pop,
  output logic [DATA_W-1:0]       rdata,
  output logic [NREQ-1:0]         rvalid,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic                    busy,
  output logic                    core_ena,
  output logic                    core_rw,
  output logic [ADDR_W-1:0]       core_addr,
  output logic [NBYTE_W-1:0]      core_nbyte,
  output logic [DATA_W-1:0]       core_wdata,
  input  logic                    core_req_w,
  input  logic                    core_valid,
  input  logic [DATA_W-1:0]       core_rdata,
  input  logic                    core_free_w,
  input  logic                    core_free_r
);

  localparam int GNT_W = clog2(NREQ);
  localparam int WD_W  = clog2(TIMEOUT) + 1;
  localparam int GAP_W = clog2(BUS_GAP) + 1;

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [GNT_W-1:0]    r_gnt;
  logic [GNT_W-1:0]    r_rr;
  logic [WD_W-1:0]     r_wdog;
  logic [GAP_W-1:0]    r_gap;
  logic                r_free_w_d;
  logic                r_free_r_d;
  logic                r_core_ena;
  logic                r_core_rw;
  logic [ADDR_W-1:0]   r_core_addr;
  logic [NBYTE_W-1:0]  r_core_nbyte;
  logic [DATA_W-1:0]   r_rdata;
  logic [NREQ-1:0]     r_rvalid;
  logic [NREQ-1:0]     r_done;
  logic [NREQ-1:0]     r_err;

  logic [GNT_W-1:0]    w_pick_idx;
  logic                w_pick_found;
  logic [NREQ-1:0]     w_gnt_oh;
  logic [ADDR_W-1:0]   w_addr_arr  [NREQ];
  logic [NBYTE_W-1:0]  w_nbyte_arr [NREQ];
  logic [DATA_W-1:0]   w_wdata_arr [NREQ];
  logic                w_zero_len;
  logic                w_complete;
  logic                w_timeout;
  logic                w_gap_end;
  logic                w_busy;
  logic [DATA_W-1:0]   w_core_wdata;
  logic [NREQ-1:0]     w_wdata_pop;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_nbyte_arr[gi] = req_nbyte[gi*NBYTE_W +: NBYTE_W];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  i2c_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (GNT_W)
  ) u_pick (
    .i_req   (req),
    .i_rr    (r_rr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_gnt_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
  assign w_zero_len = (w_nbyte_arr[r_gnt] == {NBYTE_W{1'b0}});
  // Only the free level for the latched direction can finish the transfer
  assign w_complete = r_core_rw ? (core_free_r & ~r_free_r_d) : (core_free_w & ~r_free_w_d);
  // Next increment reaches TIMEOUT-1, so the error shows TIMEOUT cycles after core_ena
  assign w_timeout  = (r_wdog == WD_W'(TIMEOUT - 2));
  assign w_gap_end  = (r_gap == GAP_W'(BUS_GAP - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) w_next_state = ST_LATCH;
        else              w_next_state = ST_IDLE;
      end
      ST_LATCH: begin
        if (w_zero_len) w_next_state = ST_GAP;
        else            w_next_state = ST_START;
      end
      ST_START: begin
        w_next_state = ST_XFER;
      end
      ST_XFER: begin
        if (w_complete || w_timeout) w_next_state = ST_GAP;
        else                         w_next_state = ST_XFER;
      end
      ST_GAP: begin
        if (w_gap_end) w_next_state = ST_IDLE;
        else           w_next_state = ST_GAP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: busy, write-byte mux and the same-cycle write pop
  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_core_wdata = {DATA_W{1'b0}};
    w_wdata_pop  = {NREQ{1'b0}};
    if (w_busy) w_core_wdata = w_wdata_arr[r_gnt];
    else        w_core_wdata = {DATA_W{1'b0}};
    if ((r_state == ST_XFER) && !r_core_rw && core_req_w) w_wdata_pop = w_gnt_oh;
    else                                                   w_wdata_pop = {NREQ{1'b0}};
  end

  // Grant index and round-robin pointer, captured when IDLE accepts a request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= {GNT_W{1'b0}};
      r_rr  <= GNT_W'(NREQ - 1);
    end else if ((r_state == ST_IDLE) && w_pick_found) begin
      r_gnt <= w_pick_idx;
      r_rr  <= w_pick_idx;
    end
  end

  // Command latch from the granted client
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rw    <= 1'b0;
      r_core_addr  <= {ADDR_W{1'b0}};
      r_core_nbyte <= {NBYTE_W{1'b0}};
    end else if (r_state == ST_LATCH) begin
      r_core_rw    <= req_rw[r_gnt];
      r_core_addr  <= w_addr_arr[r_gnt];
      r_core_nbyte <= w_nbyte_arr[r_gnt];
    end
  end

  // Watchdog (cleared in START, counts XFER cycles) and idle-gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= {WD_W{1'b0}};
      r_gap  <= {GAP_W{1'b0}};
    end else begin
      if (r_state == ST_START)     r_wdog <= {WD_W{1'b0}};
      else if (r_state == ST_XFER) r_wdog <= r_wdog + WD_W'(1);
      if (r_state == ST_GAP) r_gap <= r_gap + GAP_W'(1);
      else                   r_gap <= {GAP_W{1'b0}};
    end
  end

  // Registered strobes, read-data capture and free-level history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_ena <= 1'b0;
      r_done     <= {NREQ{1'b0}};
      r_err      <= {NREQ{1'b0}};
      r_rvalid   <= {NREQ{1'b0}};
      r_rdata    <= {DATA_W{1'b0}};
      r_free_w_d <= 1'b0;
      r_free_r_d <= 1'b0;
    end else begin
      r_free_w_d <= core_free_w;
      r_free_r_d <= core_free_r;
      r_core_ena <= (r_state == ST_LATCH) && !w_zero_len;
      r_done     <= ((r_state == ST_XFER) && w_complete) ? w_gnt_oh : {NREQ{1'b0}};
      // Completion takes priority over a coincident timeout
      r_err      <= (((r_state == ST_LATCH) && w_zero_len) ||
                     ((r_state == ST_XFER) && !w_complete && w_timeout)) ? w_gnt_oh : {NREQ{1'b0}};
      if ((r_state == ST_XFER) && r_core_rw && core_valid) begin
        r_rvalid <= w_gnt_oh;
        r_rdata  <= core_rdata;
      end else begin
        r_rvalid <= {NREQ{1'b0}};
      end
    end
  end

  assign busy       = w_busy;
  assign core_ena   = r_core_ena;
  assign core_rw    = r_core_rw;
  assign core_addr  = r_core_addr;
  assign core_nbyte = r_core_nbyte;
  assign core_wdata = w_core_wdata;
  assign wdata_pop  = w_wdata_pop;
  assign rdata      = r_rdata;
  assign rvalid     = r_rvalid;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter (NREQ=2, TIMEOUT=16, BUS_GAP=8).
// The expected grant comes from a plain "next requester after the last
// grant" rule. Expected pops, read bytes, pulses and cycle positions come
// from the transaction sequence that the bench itself drives.
module tb_i2c_master_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int BUS_GAP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic        cl_rw    [2];
  logic [6:0]  cl_addr  [2];
  logic [4:0]  cl_nbyte [2];
  logic [7:0]  cl_wdata [2];
  logic [1:0]  req_rw;
  logic [13:0] req_addr;
  logic [9:0]  req_nbyte;
  logic [15:0] req_wdata;
  logic [1:0]  wdata_pop, rvalid, done, err;
  logic [7:0]  rdata, core_wdata, core_rdata;
  logic        busy, core_ena, core_rw;
  logic [6:0]  core_addr;
  logic [4:0]  core_nbyte;
  logic        core_req_w = 1'b0, core_valid = 1'b0, core_free_w = 1'b0, core_free_r = 1'b0;

  int checks = 0;
  int failures = 0;
  int model_rr = 1;
  logic [7:0] rd_plan [$];

  assign req_rw    = {cl_rw[1], cl_rw[0]};
  assign req_addr  = {cl_addr[1], cl_addr[0]};
  assign req_nbyte = {cl_nbyte[1], cl_nbyte[0]};
  assign req_wdata = {cl_wdata[1], cl_wdata[0]};

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .BUS_GAP(BUS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_nbyte(req_nbyte), .req_wdata(req_wdata), .wdata_pop(wdata_pop), .rdata(rdata),
    .rvalid(rvalid), .done(done), .err(err), .busy(busy), .core_ena(core_ena),
    .core_rw(core_rw), .core_addr(core_addr), .core_nbyte(core_nbyte), .core_wdata(core_wdata),
    .core_req_w(core_req_w), .core_valid(core_valid), .core_rdata(core_rdata),
    .core_free_w(core_free_w), .core_free_r(core_free_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: the first requester after the last grant, with wrap-around
  function automatic int pick(input logic [1:0] r, input int last);
    int c;
    pick = -1;
    for (int k = 1; k <= 2; k++) begin
      c = (last + k) % 2;
      if (r[c] && pick < 0) pick = c;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ena"}, core_ena, 0);
    check({tag, "_pop"}, wdata_pop, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_addr"}, core_addr, 0);
    check({tag, "_rw"}, core_rw, 0);
    check({tag, "_nbyte"}, core_nbyte, 0);
    check({tag, "_wdata"}, core_wdata, 0);
  endtask

  // The first gap cycle has already been checked; check the rest, then the return to IDLE
  task automatic gap_tail();
    for (int i = 0; i < BUS_GAP - 1; i++) begin
      @(negedge clk); #1;
      check("gap_busy", busy, 1);
      check("gap_done", done, 0);
      check("gap_err", err, 0);
      check("gap_ena", core_ena, 0);
    end
    @(negedge clk); #1;
    check("gap_end_busy", busy, 0);
  endtask

  // Runs one transaction. Entry is at a negedge in IDLE with req already driven.
  task automatic txn(input bit drop_req);
    int g, n;
    logic [1:0] oh;
    logic [7:0] b;
    g = pick(req, model_rr);
    model_rr = g;
    oh = 2'b01 << g;
    n = int'(cl_nbyte[g]);
    #1;
    check("idle_busy", busy, 0);
    check("idle_ena", core_ena, 0);
    @(negedge clk); #1;                       // LATCH
    if (drop_req) req = 2'b00;
    check("latch_busy", busy, 1);
    check("latch_ena", core_ena, 0);
    if (n == 0) begin
      @(negedge clk); #1;                     // first gap cycle
      check("zlen_err", err, oh);
      check("zlen_done", done, 0);
      check("zlen_ena", core_ena, 0);
      gap_tail();
    end else begin
      @(negedge clk); #1;                     // START: third cycle after req
      check("start_ena", core_ena, 1);
      check("start_addr", core_addr, cl_addr[g]);
      check("start_rw", core_rw, cl_rw[g]);
      check("start_nbyte", core_nbyte, cl_nbyte[g]);
      check("start_wdata", core_wdata, cl_wdata[g]);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (!cl_rw[g]) begin
          core_req_w = 1'b1;
          core_valid = 1'($urandom_range(0, 1));
          #1;
          check("wr_pop", wdata_pop, oh);
          check("wr_wdata", core_wdata, cl_wdata[g]);
          check("wr_ena_off", core_ena, 0);
          @(negedge clk);
          core_req_w = 1'b0;
          core_valid = 1'b0;
          cl_wdata[g] = 8'($urandom);
          #1;
          check("wr_pop_off", wdata_pop, 0);
          check("wr_no_rvalid", rvalid, 0);
          check("wr_done_early", done, 0);
        end else begin
          b = (rd_plan.size() > 0) ? rd_plan.pop_front() : 8'($urandom);
          core_valid = 1'b1;
          core_rdata = b;
          core_req_w = 1'($urandom_range(0, 1));
          #1;
          check("rd_no_pop", wdata_pop, 0);
          check("rd_rvalid_wait", rvalid, 0);
          @(negedge clk);
          core_valid = 1'b0;
          core_req_w = 1'b0;
          core_rdata = 8'($urandom);
          #1;
          check("rd_rvalid", rvalid, oh);
          check("rd_rdata", rdata, b);
          check("rd_done_early", done, 0);
        end
      end
      // A rise on the other direction's free level must not finish the transfer
      @(negedge clk);
      if (cl_rw[g]) core_free_w = 1'b1;
      else          core_free_r = 1'b1;
      @(negedge clk);
      core_free_w = 1'b0;
      core_free_r = 1'b0;
      #1;
      check("opp_free_done", done, 0);
      check("opp_free_busy", busy, 1);
      @(negedge clk);
      if (cl_rw[g]) core_free_r = 1'b1;
      else          core_free_w = 1'b1;
      @(negedge clk); #1;                     // first gap cycle
      check("done_pulse", done, oh);
      check("done_err", err, 0);
      check("done_busy", busy, 1);
      core_free_w = 1'b0;
      core_free_r = 1'b0;
      gap_tail();
    end
  endtask

  task automatic rand_client(input int c, input bit allow_zero);
    cl_rw[c]    = 1'($urandom_range(0, 1));
    cl_addr[c]  = 7'($urandom);
    cl_nbyte[c] = (allow_zero && ($urandom_range(0, 3) == 0)) ? 5'd0 : 5'($urandom_range(1, 5));
    cl_wdata[c] = 8'($urandom);
  endtask

  initial begin
    int g;
    for (int c = 0; c < 2; c++) begin
      cl_rw[c] = 1'b0; cl_addr[c] = 7'd0; cl_nbyte[c] = 5'd0; cl_wdata[c] = 8'd0;
    end
    core_rdata = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write from client 0
    cl_addr[0] = 7'h50; cl_rw[0] = 1'b0; cl_nbyte[0] = 5'd3; cl_wdata[0] = 8'h11;
    req = 2'b01;
    txn(1'b1);

    // Single read from client 1 with fixed bytes
    cl_addr[1] = 7'h3C; cl_rw[1] = 1'b1; cl_nbyte[1] = 5'd2;
    rd_plan.push_back(8'hA5);
    rd_plan.push_back(8'h5A);
    req = 2'b10;
    txn(1'b1);

    // Both clients are held requesting; the grant must alternate
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      rand_client(0, 1'b0);
      rand_client(1, 1'b0);
      txn(1'b0);
    end

    // Zero-length request is rejected without enabling the core
    cl_nbyte[0] = 5'd0;
    req = 2'b01;
    txn(1'b1);

    // Randomized mix of request patterns and commands
    for (int t = 0; t < 6; t++) begin
      rand_client(0, 1'b1);
      rand_client(1, 1'b1);
      req = 2'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)));
    end

    // Watchdog: the core never frees
    cl_rw[0] = 1'b0; cl_addr[0] = 7'h22; cl_nbyte[0] = 5'd3;
    req = 2'b01;
    g = pick(req, model_rr);
    model_rr = g;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk); #1;
    check("to_ena", core_ena, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(negedge clk); #1;
      check("to_err_early", err, 0);
      check("to_done", done, 0);
    end
    @(negedge clk); #1;
    check("to_err", err, 2'b01 << g);
    core_free_w = 1'b1;
    @(negedge clk); #1;
    check("to_late_done", done, 0);
    core_free_w = 1'b0;
    for (int i = 0; i < BUS_GAP - 2; i++) begin
      @(negedge clk); #1;
      check("to_gap_busy", busy, 1);
      check("to_gap_done", done, 0);
    end
    @(negedge clk); #1;
    check("to_idle", busy, 0);

    // Reset during the second write byte of client 1
    cl_rw[1] = 1'b0; cl_addr[1] = 7'h41; cl_nbyte[1] = 5'd4; cl_wdata[1] = 8'h77;
    req = 2'b10;
    g = pick(req, model_rr);
    model_rr = g;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    core_req_w = 1'b1;
    #1;
    check("rst_pop1", wdata_pop, 2'b01 << g);
    @(negedge clk);
    core_req_w = 1'b0;
    cl_wdata[1] = 8'h78;
    @(negedge clk);
    core_req_w = 1'b1;
    #1;
    check("rst_pop2", wdata_pop, 2'b01 << g);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    core_req_w = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_rr = 1;
    rand_client(0, 1'b0);
    rand_client(1, 1'b0);
    req = 2'b11;
    txn(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
